mmio_initiator: RTL and testbench



---
 rtl/mmio_pkg.sv | 6 +
 rtl/mmio_slot_decode.sv | 18 +
 rtl/mmio_initiator.sv | 106 ++++++++++
 tb/tb_mmio_initiator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the MMIO slot initiator.
package mmio_pkg;
    localparam int SLOT_ADDR_W = 8;
    typedef enum logic [1:0] {OK, SLAVE_ERR, DECODE_ERR, TIMEOUT} resp_err_e;
    typedef enum logic [1:0] {IDLE, WAIT, COMPLETE} state_e;
endpackage

// File: rtl/mmio_slot_decode.sv
// mmio_slot_decode: window hit and one-hot slot select from a byte address.
module mmio_slot_decode
    import mmio_pkg::*;
#(
    parameter int          NUM_SLOTS = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic [31:0]          req_addr,
    output logic                 hit,
    output logic [NUM_SLOTS-1:0] select
);
    localparam int SW  = $clog2(NUM_SLOTS);
    localparam int TOP = SLOT_ADDR_W + SW;
    logic unused_offset;
    assign hit           = req_addr[31:TOP] == BASE_ADDR[31:TOP];
    assign select        = NUM_SLOTS'(1) << req_addr[SLOT_ADDR_W +: SW];
    assign unused_offset = ^req_addr[SLOT_ADDR_W-1:0];
endmodule

// File: rtl/mmio_initiator.sv
// mmio_initiator: single-outstanding MMIO bus master driving the slot interface.
// Optional watchdog enabled by defining MMIO_INITIATOR_TIMEOUT_EN.
module mmio_initiator
    import mmio_pkg::*;
#(
    parameter int          NUM_SLOTS      = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        resp_valid,
    output logic [31:0]                 resp_rdata,
    output logic [1:0]                  resp_err,
    output logic [NUM_SLOTS-1:0]        chip_select,
    output logic                        read,
    output logic                        write,
    output logic [SLOT_ADDR_W-1:0]      addr,
    output logic [31:0]                 wr_data,
    output logic                        transaction_completed,
    input  logic [NUM_SLOTS-1:0][31:0]  slot_rd_data,
    input  logic [NUM_SLOTS-1:0]        slot_wr_done,
    input  logic [NUM_SLOTS-1:0]        slot_rd_done,
    input  logic [NUM_SLOTS-1:0]        slot_slave_error,
    input  logic [NUM_SLOTS-1:0]        slot_decode_error
);
    state_e state, state_n;
    logic hit, is_bus, done, de, se, timed_out, accept, finish;
    logic [NUM_SLOTS-1:0] onehot;
    logic [31:0] sel_rdata;

    mmio_slot_decode #(.NUM_SLOTS(NUM_SLOTS), .BASE_ADDR(BASE_ADDR)) u_dec (
        .req_addr(req_addr),
        .hit(hit),
        .select(onehot)
    );

    // chip_select is the latched one-hot, so it doubles as the slot mask in WAIT
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            sel_rdata = sel_rdata | (chip_select[i] ? slot_rd_data[i] : 32'h0);
    end
    assign done = |(chip_select & (write ? slot_wr_done : slot_rd_done));
    assign de   = |(chip_select & slot_decode_error);
    assign se   = |(chip_select & slot_slave_error);

`ifdef MMIO_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = TIMEOUT_CYCLES < 256 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge arst) begin
        if (arst) cnt <= '0;
        else cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
    end
    assign timed_out = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    assign timed_out = TIMEOUT_CYCLES < 0;
`endif

    assign accept                = state == IDLE && req_valid;
    assign finish                = state == WAIT && (done || timed_out);
    assign req_ready             = state == IDLE;
    assign resp_valid            = state == COMPLETE;
    assign transaction_completed = state == COMPLETE && is_bus;

    always_comb begin
        state_n = accept ? (hit ? WAIT : COMPLETE) : finish ? COMPLETE : state == COMPLETE ? IDLE : state;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            chip_select <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            addr        <= '0;
            wr_data     <= '0;
            resp_rdata  <= '0;
            resp_err    <= OK;
            is_bus      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                chip_select <= hit ? onehot : '0;
                read        <= hit && !req_write;
                write       <= hit && req_write;
                addr        <= req_addr[SLOT_ADDR_W-1:0];
                wr_data     <= req_wdata;
                resp_rdata  <= '0;
                resp_err    <= hit ? OK : DECODE_ERR;
                is_bus      <= hit;
            end else if (finish) begin
                chip_select <= '0;
                read        <= 1'b0;
                write       <= 1'b0;
                resp_err    <= !done ? TIMEOUT : de ? DECODE_ERR : se ? SLAVE_ERR : OK;
                resp_rdata  <= (done && read && !de && !se) ? sel_rdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_mmio_initiator.sv
// tb_mmio_initiator: directed checks of the MMIO initiator (timeout steps need MMIO_INITIATOR_TIMEOUT_EN).
module tb_mmio_initiator;
    logic clk = 1'b0, arst = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, resp_valid, read, write, transaction_completed;
    logic [31:0] resp_rdata, wr_data;
    logic [1:0] resp_err;
    logic [3:0] chip_select;
    logic [7:0] addr;
    logic [3:0][31:0] slot_rd_data = '0;
    logic [3:0] slot_wr_done = '0, slot_rd_done = '0, slot_slave_error = '0, slot_decode_error = '0;
    int errors = 0, checks = 0;

    mmio_initiator #(.NUM_SLOTS(4), .BASE_ADDR(32'h8000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .chip_select(chip_select), .read(read), .write(write), .addr(addr),
        .wr_data(wr_data), .transaction_completed(transaction_completed),
        .slot_rd_data(slot_rd_data), .slot_wr_done(slot_wr_done), .slot_rd_done(slot_rd_done),
        .slot_slave_error(slot_slave_error), .slot_decode_error(slot_decode_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // present a request before edge 0, return in cycle 1 with req_valid dropped
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        cyc(1);
        req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(2);
        chk("rst_ready", req_ready, 1);
        chk("rst_cs", chip_select, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_tc", transaction_completed, 0);
        chk("rst_rw", {read, write}, 0);
        arst = 1'b0;
        cyc(1);

        // store 0x1 to slot 0, done in cycle 3
        issue(1'b1, 32'h8000_0000, 32'h1);
        chk("st_c1_cs", chip_select, 4'b0001);
        chk("st_c1_wr", {read, write}, 2'b01);
        chk("st_c1_wdata", wr_data, 32'h1);
        chk("st_c1_ready", req_ready, 0);
        cyc(1);
        chk("st_c2_cs", chip_select, 4'b0001);
        chk("st_c2_rv", resp_valid, 0);
        cyc(1);
        chk("st_c3_wr", write, 1);
        slot_wr_done[0] = 1'b1;
        cyc(1);
        slot_wr_done[0] = 1'b0;
        chk("st_c4_rv", resp_valid, 1);
        chk("st_c4_tc", transaction_completed, 1);
        chk("st_c4_err", resp_err, 2'b00);
        chk("st_c4_cs", chip_select, 0);
        chk("st_c4_wr", write, 0);
        chk("st_c4_ready", req_ready, 0);
        cyc(1);
        chk("st_c5_ready", req_ready, 1);
        chk("st_c5_tc", transaction_completed, 0);
        chk("st_c5_rv", resp_valid, 0);

        // load slot 1 offset 0x10; wrong-type and other-slot dones must be ignored
        issue(1'b0, 32'h8000_0110, 32'h0);
        chk("ld_c1_cs", chip_select, 4'b0010);
        chk("ld_c1_rd", {read, write}, 2'b10);
        chk("ld_c1_addr", addr, 8'h10);
        slot_wr_done[1] = 1'b1; slot_rd_done[0] = 1'b1; slot_rd_data[0] = 32'hDEAD_BEEF;
        cyc(1);
        slot_wr_done[1] = 1'b0; slot_rd_done[0] = 1'b0;
        cyc(1);
        chk("ld_c3_held_cs", chip_select, 4'b0010);
        chk("ld_c3_held_addr", addr, 8'h10);
        chk("ld_c3_rv", resp_valid, 0);
        slot_rd_done[1] = 1'b1; slot_rd_data[1] = 32'h1;
        cyc(1);
        slot_rd_done[1] = 1'b0; slot_rd_data[1] = 32'h0;
        chk("ld_rv", resp_valid, 1);
        chk("ld_rdata", resp_rdata, 32'h1);
        chk("ld_err", resp_err, 2'b00);
        chk("ld_tc", transaction_completed, 1);
        cyc(1);

        // slot 2 slave error: error code 01, data forced to 0
        issue(1'b0, 32'h8000_0200, 32'h0);
        chk("se_cs", chip_select, 4'b0100);
        slot_rd_done[2] = 1'b1; slot_slave_error[2] = 1'b1; slot_rd_data[2] = 32'h55;
        cyc(1);
        slot_rd_done[2] = 1'b0; slot_slave_error[2] = 1'b0;
        chk("se_rv", resp_valid, 1);
        chk("se_err", resp_err, 2'b01);
        chk("se_rdata", resp_rdata, 32'h0);
        cyc(1);

        // decode error wins over slave error
        issue(1'b0, 32'h8000_0200, 32'h0);
        slot_rd_done[2] = 1'b1; slot_slave_error[2] = 1'b1; slot_decode_error[2] = 1'b1;
        cyc(1);
        slot_rd_done[2] = 1'b0; slot_slave_error[2] = 1'b0; slot_decode_error[2] = 1'b0;
        chk("de_err", resp_err, 2'b10);
        chk("de_rdata", resp_rdata, 32'h0);
        chk("de_tc", transaction_completed, 1);
        cyc(1);

        // local decode miss outside the window
        issue(1'b0, 32'h9000_0000, 32'h0);
        chk("miss_rv", resp_valid, 1);
        chk("miss_err", resp_err, 2'b10);
        chk("miss_cs", chip_select, 0);
        chk("miss_tc", transaction_completed, 0);
        chk("miss_rd", read, 0);
        cyc(1);
        chk("miss_c2_ready", req_ready, 1);
        chk("miss_c2_rv", resp_valid, 0);

        // just past the last slot is also a miss
        issue(1'b1, 32'h8000_0400, 32'h7);
        chk("miss2_err", resp_err, 2'b10);
        chk("miss2_wr", write, 0);
        cyc(1);

        // last slot, top offset
        issue(1'b1, 32'h8000_03FC, 32'hA5A5_0003);
        chk("s3_cs", chip_select, 4'b1000);
        chk("s3_addr", addr, 8'hFC);
        chk("s3_wdata", wr_data, 32'hA5A5_0003);
        slot_wr_done[3] = 1'b1;
        cyc(1);
        slot_wr_done[3] = 1'b0;
        chk("s3_err", resp_err, 2'b00);
        chk("s3_rdata", resp_rdata, 32'h0);
        cyc(1);

        // asynchronous reset during WAIT
        issue(1'b0, 32'h8000_0000, 32'h0);
        cyc(1);
        arst = 1'b1;
        #1;
        chk("arst_cs", chip_select, 0);
        chk("arst_rd", read, 0);
        chk("arst_ready", req_ready, 1);
        chk("arst_rv", resp_valid, 0);
        cyc(1);
        arst = 1'b0;
        issue(1'b1, 32'h8000_0100, 32'h42);
        chk("post_cs", chip_select, 4'b0010);
        slot_wr_done[1] = 1'b1;
        cyc(1);
        slot_wr_done[1] = 1'b0;
        chk("post_rv", resp_valid, 1);
        chk("post_err", resp_err, 2'b00);
        chk("post_tc", transaction_completed, 1);
        cyc(1);

`ifdef MMIO_INITIATOR_TIMEOUT_EN
        // silent slot: 16 WAIT cycles, response in the following cycle
        issue(1'b0, 32'h8000_0000, 32'h0);
        cyc(15);
        chk("to_c16_rv", resp_valid, 0);
        chk("to_c16_cs", chip_select, 4'b0001);
        cyc(1);
        chk("to_rv", resp_valid, 1);
        chk("to_err", resp_err, 2'b11);
        chk("to_rdata", resp_rdata, 32'h0);
        chk("to_tc", transaction_completed, 1);
        cyc(1);
        // done on the timeout cycle wins
        issue(1'b0, 32'h8000_0000, 32'h0);
        cyc(15);
        slot_rd_done[0] = 1'b1; slot_rd_data[0] = 32'h77;
        cyc(1);
        slot_rd_done[0] = 1'b0;
        chk("to_done_err", resp_err, 2'b00);
        chk("to_done_rdata", resp_rdata, 32'h77);
        cyc(1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
